// File: rtl/wave_frame_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : wave_frame_seq
// Purpose  : Clears the FFT-modulus RAM writer, triggers one FFT frame, waits
//            for the writer, then sweeps the RAM for the strongest bin.
// Revision : 1.0 - initial release
// ============================================================================
module wave_frame_seq #(
    parameter int unsigned SKIP_BINS  = 1,
    parameter int unsigned LAST_ADDR  = 253,
    parameter int unsigned CLR_CYCLES = 2,
    parameter int unsigned TIMEOUT    = 65535
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        mode_cont,
    input  logic        wr_done,
    output logic        wr_clr_n,
    output logic        fft_start,
    output logic        rd_en,
    output logic [7:0]  rd_addr,
    input  logic [15:0] rd_data,
    output logic [7:0]  peak_addr,
    output logic [15:0] peak_val,
    output logic        busy,
    output logic        frame_done,
    output logic        timeout_err
);

    localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
    localparam int unsigned CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

    localparam logic [7:0]       FIRST_ADDR = 8'(SKIP_BINS);
    localparam logic [7:0]       FINAL_ADDR = 8'(LAST_ADDR);
    localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(TIMEOUT - 1);
    localparam logic [CLR_W-1:0] CLR_LAST   = CLR_W'(CLR_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_CLEAR   = 3'd1,
        S_ARM     = 3'd2,
        S_CAPTURE = 3'd3,
        S_SCAN    = 3'd4,
        S_DONE    = 3'd5,
        S_ERR     = 3'd6
    } state_t;

    state_t            state;
    logic [CLR_W-1:0]  clr_cnt;
    logic [TO_W-1:0]   to_cnt;
    logic              cmp_valid;
    logic [7:0]        cmp_addr;
    logic [15:0]       max_val;
    logic [7:0]        max_addr;

    logic              better;
    logic [15:0]       nmax_val;
    logic [7:0]        nmax_addr;

    // Strict greater-than keeps the lowest address on ties.
    always_comb begin
        better    = cmp_valid && (rd_data > max_val);
        nmax_val  = better ? rd_data  : max_val;
        nmax_addr = better ? cmp_addr : max_addr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            clr_cnt     <= '0;
            to_cnt      <= '0;
            cmp_valid   <= 1'b0;
            cmp_addr    <= '0;
            max_val     <= '0;
            max_addr    <= '0;
            wr_clr_n    <= 1'b1;
            fft_start   <= 1'b0;
            rd_en       <= 1'b0;
            rd_addr     <= '0;
            peak_addr   <= '0;
            peak_val    <= '0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state       <= S_CLEAR;
                        busy        <= 1'b1;
                        wr_clr_n    <= 1'b0;
                        clr_cnt     <= '0;
                        timeout_err <= 1'b0;
                    end
                end

                S_CLEAR: begin
                    if (clr_cnt == CLR_LAST) begin
                        state     <= S_ARM;
                        wr_clr_n  <= 1'b1;
                        fft_start <= 1'b1;
                    end else begin
                        clr_cnt <= clr_cnt + CLR_W'(1);
                    end
                end

                S_ARM: begin
                    fft_start <= 1'b0;
                    to_cnt    <= '0;
                    state     <= S_CAPTURE;
                end

                S_CAPTURE: begin
                    // A completion on the final allowed cycle beats the timeout.
                    if (wr_done) begin
                        state     <= S_SCAN;
                        rd_en     <= 1'b1;
                        rd_addr   <= FIRST_ADDR;
                        cmp_valid <= 1'b0;
                        max_val   <= '0;
                        max_addr  <= FIRST_ADDR;
                    end else if (to_cnt == TO_LAST) begin
                        state <= S_ERR;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end

                S_SCAN: begin
                    max_val  <= nmax_val;
                    max_addr <= nmax_addr;
                    if (cmp_valid && (cmp_addr == FINAL_ADDR)) begin
                        state      <= S_DONE;
                        rd_en      <= 1'b0;
                        cmp_valid  <= 1'b0;
                        peak_addr  <= nmax_addr;
                        peak_val   <= nmax_val;
                        frame_done <= 1'b1;
                    end else begin
                        // Data for rd_addr returns next cycle; tag it for that compare.
                        cmp_valid <= 1'b1;
                        cmp_addr  <= rd_addr;
                        if (rd_addr != FINAL_ADDR) begin
                            rd_addr <= rd_addr + 8'd1;
                        end
                    end
                end

                S_DONE: begin
                    frame_done <= 1'b0;
                    if (mode_cont) begin
                        state    <= S_CLEAR;
                        wr_clr_n <= 1'b0;
                        clr_cnt  <= '0;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end

                S_ERR: begin
                    timeout_err <= 1'b1;
                    busy        <= 1'b0;
                    state       <= S_IDLE;
                end

                default: begin
                    state      <= S_IDLE;
                    busy       <= 1'b0;
                    wr_clr_n   <= 1'b1;
                    fft_start  <= 1'b0;
                    rd_en      <= 1'b0;
                    frame_done <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_wave_frame_seq.sv
`timescale 1ns/1ps
`default_nettype none
// Directed bench for wave_frame_seq: default instance plus a short-timeout instance.
module tb_wave_frame_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start, mode_cont, wr_done;
    logic        wr_clr_n, fft_start, rd_en, busy, frame_done, timeout_err;
    logic [7:0]  rd_addr, peak_addr;
    logic [15:0] rd_data, peak_val;

    logic        start_t, wr_done_t;
    logic        wr_clr_n_t, fft_start_t, rd_en_t, busy_t, frame_done_t, timeout_err_t;
    logic [7:0]  rd_addr_t, peak_addr_t;
    logic [15:0] rd_data_t, peak_val_t;

    logic [15:0] mem [256];
    int n_checks = 0;
    int n_fail   = 0;
    int fd_cnt   = 0;

    always #5 clk = ~clk;

    wave_frame_seq dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mode_cont(mode_cont),
        .wr_done(wr_done), .wr_clr_n(wr_clr_n), .fft_start(fft_start),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .peak_addr(peak_addr), .peak_val(peak_val), .busy(busy),
        .frame_done(frame_done), .timeout_err(timeout_err)
    );

    wave_frame_seq #(.TIMEOUT(16)) dut_t (
        .clk(clk), .rst_n(rst_n), .start(start_t), .mode_cont(1'b0),
        .wr_done(wr_done_t), .wr_clr_n(wr_clr_n_t), .fft_start(fft_start_t),
        .rd_en(rd_en_t), .rd_addr(rd_addr_t), .rd_data(rd_data_t),
        .peak_addr(peak_addr_t), .peak_val(peak_val_t), .busy(busy_t),
        .frame_done(frame_done_t), .timeout_err(timeout_err_t)
    );

    // Synchronous-read RAM models: data one cycle after address.
    always @(posedge clk) begin
        if (rd_en)   rd_data   <= mem[rd_addr];
        if (rd_en_t) rd_data_t <= mem[rd_addr_t];
    end

    always @(negedge clk) if (frame_done) fd_cnt <= fd_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [15:0] v);
        for (int i = 0; i < 256; i++) mem[i] = v;
    endtask

    // Waits for frame_done; n counts negedges starting at the first SCAN cycle.
    task automatic wait_fd(output int n);
        n = 1;
        while (!frame_done && n < 400) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic run_frame(input string tag, input int dly,
                             input logic [7:0] ea, input logic [15:0] ev);
        int n;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, " clr_low"}, wr_clr_n, 0);
        chk({tag, " busy_hi"}, busy, 1);
        n = 0;
        while (!fft_start && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " arm_cycle"}, n, 2);
        repeat (dly) @(negedge clk);
        wr_done = 1'b1;
        @(negedge clk);
        chk({tag, " scan_en"}, rd_en, 1);
        chk({tag, " scan_first"}, rd_addr, 1);
        wait_fd(n);
        chk({tag, " latency"}, n, 255);
        chk({tag, " peak_addr"}, peak_addr, ea);
        chk({tag, " peak_val"}, peak_val, ev);
        wr_done = 1'b0;
    endtask

    initial begin
        int n, fd0;
        rst_n = 1'b0; start = 1'b0; mode_cont = 1'b0; wr_done = 1'b0;
        start_t = 1'b0; wr_done_t = 1'b0;
        fill(16'd0);
        repeat (3) @(negedge clk);
        chk("rst wr_clr_n", wr_clr_n, 1);
        chk("rst fft_start", fft_start, 0);
        chk("rst rd_en", rd_en, 0);
        chk("rst rd_addr", rd_addr, 0);
        chk("rst peak", {peak_addr, peak_val}, 0);
        chk("rst busy", busy, 0);
        chk("rst frame_done", frame_done, 0);
        chk("rst timeout_err", timeout_err, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Single frame
        fill(16'd100);
        mem[57] = 16'h7F00;
        fd0 = fd_cnt;
        run_frame("single", 20, 8'd57, 16'h7F00);
        chk("single busy_in_done", busy, 1);
        @(negedge clk);
        chk("single busy_fall", busy, 0);
        chk("single fd_pulse", frame_done, 0);
        repeat (5) @(negedge clk);
        chk("single fd_once", fd_cnt - fd0, 1);

        // Tie and DC skip
        fill(16'd0);
        mem[0] = 16'hFFFF; mem[30] = 16'h4000; mem[90] = 16'h4000;
        run_frame("tie", 7, 8'd30, 16'h4000);
        repeat (3) @(negedge clk);

        // Short-timeout instance: one good frame, then a timeout
        start_t = 1'b1; @(negedge clk); start_t = 1'b0;
        repeat (6) @(negedge clk);
        wr_done_t = 1'b1;
        n = 0;
        while (!frame_done_t && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("tsetup peak_addr", peak_addr_t, 30);
        wr_done_t = 1'b0;
        repeat (3) @(negedge clk);
        start_t = 1'b1; @(negedge clk); start_t = 1'b0;
        repeat (18) @(negedge clk);
        chk("tmo capture_last busy", busy_t, 1);
        chk("tmo capture_last err", timeout_err_t, 0);
        @(negedge clk);
        chk("tmo err_state busy", busy_t, 1);
        @(negedge clk);
        chk("tmo err_flag", timeout_err_t, 1);
        chk("tmo idle", busy_t, 0);
        chk("tmo peak_addr kept", peak_addr_t, 30);
        chk("tmo peak_val kept", peak_val_t, 16'h4000);
        repeat (3) @(negedge clk);
        start_t = 1'b1; @(negedge clk); start_t = 1'b0;
        chk("tmo err_cleared", timeout_err_t, 0);
        repeat (25) @(negedge clk);

        // Continuous mode; drop mode_cont during the second frame
        fill(16'd0);
        mem[120] = 16'h1234;
        mode_cont = 1'b1;
        run_frame("cont1", 10, 8'd120, 16'h1234);
        mem[120] = 16'd0; mem[200] = 16'h2222;
        @(negedge clk);
        chk("cont reclr1", wr_clr_n, 0);
        chk("cont busy", busy, 1);
        mode_cont = 1'b0;
        @(negedge clk);
        chk("cont reclr2", wr_clr_n, 0);
        @(negedge clk);
        chk("cont reclr_end", wr_clr_n, 1);
        chk("cont rearm", fft_start, 1);
        repeat (10) @(negedge clk);
        wr_done = 1'b1;
        @(negedge clk);
        wait_fd(n);
        chk("cont2 latency", n, 255);
        chk("cont2 peak_addr", peak_addr, 200);
        chk("cont2 peak_val", peak_val, 16'h2222);
        wr_done = 1'b0;
        @(negedge clk);
        chk("cont2 to_idle", busy, 0);
        repeat (5) @(negedge clk);
        chk("cont2 no_reclear", wr_clr_n, 1);

        // start pulsed during SCAN is dropped
        fd0 = fd_cnt;
        start = 1'b1; @(negedge clk); start = 1'b0;
        repeat (6) @(negedge clk);
        wr_done = 1'b1;
        repeat (50) @(negedge clk);
        start = 1'b1; @(negedge clk); start = 1'b0;
        wait_fd(n);
        wr_done = 1'b0;
        repeat (300) @(negedge clk);
        chk("scanstart fd_count", fd_cnt - fd0, 1);
        chk("scanstart idle", busy, 0);

        // Reset mid-SCAN
        start = 1'b1; @(negedge clk); start = 1'b0;
        repeat (6) @(negedge clk);
        wr_done = 1'b1;
        repeat (30) @(negedge clk);
        fd0 = fd_cnt;
        #2 rst_n = 1'b0;
        #1;
        chk("midrst rd_en", rd_en, 0);
        chk("midrst rd_addr", rd_addr, 0);
        chk("midrst busy", busy, 0);
        chk("midrst peak", {peak_addr, peak_val}, 0);
        chk("midrst wr_clr_n", wr_clr_n, 1);
        @(negedge clk);
        wr_done = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (300) @(negedge clk);
        chk("midrst no_fd", fd_cnt - fd0, 0);
        run_frame("postrst", 4, 8'd200, 16'h2222);
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
